// File: rtl/vga_sym_render.sv
// vga_sym_render: free-running 3-stage text-mode pixel pipeline (text RAM -> font ROM -> palette).
// Define VGA_CURSOR_EN to add a blinking underline cursor (frame_start, cur_addr ports).
module vga_sym_render (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    input  logic [2:0]  pix_x,
    input  logic [3:0]  pix_y,
    input  logic [6:0]  disp_x,
    input  logic [13:0] disp_y,
`ifdef VGA_CURSOR_EN
    input  logic        frame_start,
    input  logic [11:0] cur_addr,
`endif
    output logic [11:0] txt_addr,
    input  logic [15:0] txt_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        rgb_valid,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue
);
    logic [13:0] sum;
    logic [11:0] sym_addr;
    logic        valid_1, valid_2;
    logic [2:0]  pix_x_1, pix_x_2;
    logic [3:0]  pix_y_1;
    logic [7:0]  attr_2;
    logic        pix_bit;
    logic [3:0]  idx;
    logic [11:0] rgb_nxt;

    assign sum      = disp_y + 14'(disp_x);
    assign sym_addr = sum[11:0];

    // {I,R,G,B}: set bits are A/F, clear bits 0/5; index 6 is brown rather than dark yellow
    function automatic logic [11:0] palette(input logic [3:0] i);
        logic [3:0] hi, lo;
        hi = i[3] ? 4'hF : 4'hA;
        lo = i[3] ? 4'h5 : 4'h0;
        return (i == 4'd6) ? 12'hA50 : {i[2] ? hi : lo, i[1] ? hi : lo, i[0] ? hi : lo};
    endfunction

`ifdef VGA_CURSOR_EN
    logic [5:0] blink_cnt;
    logic       cur_hit_1, cur_hit_2, uline_1, uline_2;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            blink_cnt <= '0;
            cur_hit_1 <= 1'b0;
            cur_hit_2 <= 1'b0;
            uline_1   <= 1'b0;
            uline_2   <= 1'b0;
        end else begin
            blink_cnt <= blink_cnt + 6'(frame_start);
            cur_hit_1 <= sym_addr == cur_addr;
            cur_hit_2 <= cur_hit_1;
            uline_1   <= pix_y >= 4'd13;
            uline_2   <= uline_1;
        end
    end
`endif

    always_comb begin
        pix_bit = font_data[3'd7 - pix_x_2];
        idx     = pix_bit ? attr_2[3:0] : attr_2[7:4];
`ifdef VGA_CURSOR_EN
        idx     = (cur_hit_2 & uline_2 & blink_cnt[5]) ? attr_2[3:0] : idx;
`endif
        rgb_nxt = valid_2 ? palette(idx) : 12'h000;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            txt_addr  <= '0;
            valid_1   <= 1'b0;
            pix_x_1   <= '0;
            pix_y_1   <= '0;
            font_addr <= '0;
            attr_2    <= '0;
            pix_x_2   <= '0;
            valid_2   <= 1'b0;
            rgb_valid <= 1'b0;
            {red, green, blue} <= '0;
        end else begin
            txt_addr  <= sym_addr;
            valid_1   <= en;
            pix_x_1   <= pix_x;
            pix_y_1   <= pix_y;
            font_addr <= {txt_data[7:0], pix_y_1};
            attr_2    <= txt_data[15:8];
            pix_x_2   <= pix_x_1;
            valid_2   <= valid_1;
            rgb_valid <= valid_2;
            {red, green, blue} <= rgb_nxt;
        end
    end
endmodule

// File: tb/tb_vga_sym_render.sv
// tb_vga_sym_render: directed checks of addressing, latency, palette, blanking and reset;
// cursor checks are included when VGA_CURSOR_EN is defined.
module tb_vga_sym_render;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  pix_x = '0;
    logic [3:0]  pix_y = '0;
    logic [6:0]  disp_x = '0;
    logic [13:0] disp_y = '0;
    logic [11:0] txt_addr, font_addr;
    logic [15:0] txt_data = '0;
    logic [7:0]  font_data = '0;
    logic        rgb_valid;
    logic [3:0]  red, green, blue;
    int          errors = 0;
    int          checks = 0;
`ifdef VGA_CURSOR_EN
    logic        frame_start = 1'b0;
    logic [11:0] cur_addr = '0;
`endif

    vga_sym_render dut (
        .clk(clk), .resetn(resetn), .en(en), .pix_x(pix_x), .pix_y(pix_y),
        .disp_x(disp_x), .disp_y(disp_y),
`ifdef VGA_CURSOR_EN
        .frame_start(frame_start), .cur_addr(cur_addr),
`endif
        .txt_addr(txt_addr), .txt_data(txt_data), .font_addr(font_addr), .font_data(font_data),
        .rgb_valid(rgb_valid), .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one en pulse, then wait until its colour is at the output
    task automatic pixel(input logic [2:0] px, input logic [3:0] py);
        en = 1'b1; pix_x = px; pix_y = py;
        step();
        en = 1'b0;
        step();
        step();
    endtask

    initial begin
        int first, last, cnt;
        #12;
        chk("rst_txt_addr", txt_addr, 0);
        chk("rst_font_addr", font_addr, 0);
        chk("rst_valid", rgb_valid, 0);
        chk("rst_rgb", {red, green, blue}, 0);
        step();
        resetn = 1'b1;
        txt_data = 16'h1E41; font_data = 8'h80;
        disp_y = 14'd160; disp_x = 7'd5;
        step();
        en = 1'b1; pix_x = 3'd0; pix_y = 4'd3;
        step();
        en = 1'b0;
        chk("txt_addr_165", txt_addr, 165);
        chk("lat_valid_1", rgb_valid, 0);
        step();
        chk("font_addr_413", font_addr, 'h413);
        chk("lat_valid_2", rgb_valid, 0);
        step();
        chk("lat_valid_3", rgb_valid, 1);
        chk("fg_idx14", {red, green, blue}, 'hFF5);
        step();
        chk("valid_drop", rgb_valid, 0);
        chk("blank_after", {red, green, blue}, 0);
        pixel(3'd1, 4'd3);
        chk("bg_valid", rgb_valid, 1);
        chk("bg_idx1", {red, green, blue}, 'h00A);
        font_data = 8'h01;
        pixel(3'd7, 4'd3);
        chk("bit7_fg", {red, green, blue}, 'hFF5);
        pixel(3'd0, 4'd3);
        chk("bit0_bg", {red, green, blue}, 'h00A);
        txt_data = 16'h0641; font_data = 8'hFF;
        pixel(3'd4, 4'd0);
        chk("idx6_brown", {red, green, blue}, 'hA50);
        txt_data = 16'h0941;
        pixel(3'd2, 4'd0);
        chk("idx9", {red, green, blue}, 'h55F);
        txt_data = 16'h7C41; font_data = 8'h00;
        pixel(3'd2, 4'd0);
        chk("idx7", {red, green, blue}, 'hAAA);
        txt_data = 16'h1E41; font_data = 8'hAA;
        step();
        // 80-pixel burst
        first = -1; last = -1; cnt = 0;
        en = 1'b1;
        for (int i = 0; i < 90; i++) begin
            pix_x = 3'(i);
            step();
            if (i == 79) en = 1'b0;
            if (rgb_valid) begin
                cnt++;
                if (first < 0) first = i;
                last = i;
            end
        end
        chk("burst_count", cnt, 80);
        chk("burst_first", first, 2);
        chk("burst_last", last, 81);
        chk("burst_blank", {red, green, blue}, 0);
        disp_y = 14'd2720; disp_x = 7'd79;
        step();
        chk("addr_2799", txt_addr, 2799);
        disp_y = 14'd16320; disp_x = 7'd127;
        step();
        chk("addr_wrap_63", txt_addr, 63);
        // reset with three pixels in flight
        disp_y = 14'd160; disp_x = 7'd5; font_data = 8'h80; pix_x = 3'd0;
        en = 1'b1;
        step(); step(); step();
        chk("inflight_valid", rgb_valid, 1);
        #2 resetn = 1'b0;
        #1;
        chk("async_valid", rgb_valid, 0);
        chk("async_rgb", {red, green, blue}, 0);
        chk("async_txt", txt_addr, 0);
        chk("async_font", font_addr, 0);
        en = 1'b0;
        step();
        resetn = 1'b1;
        step();
        chk("post_rst_1", rgb_valid, 0);
        step();
        chk("post_rst_2", rgb_valid, 0);
        en = 1'b1;
        step();
        en = 1'b0;
        chk("post_en_1", rgb_valid, 0);
        step();
        chk("post_en_2", rgb_valid, 0);
        step();
        chk("post_en_3", rgb_valid, 1);
        chk("post_en_rgb", {red, green, blue}, 'hFF5);
`ifdef VGA_CURSOR_EN
        cur_addr = 12'd165; font_data = 8'h00;
        pixel(3'd0, 4'd13);
        chk("cur_blink_off", {red, green, blue}, 'h00A);
        frame_start = 1'b1;
        for (int i = 0; i < 32; i++) step();
        frame_start = 1'b0;
        pixel(3'd0, 4'd13);
        chk("cur_underline", {red, green, blue}, 'hFF5);
        pixel(3'd0, 4'd12);
        chk("cur_row12", {red, green, blue}, 'h00A);
        disp_x = 7'd6;
        pixel(3'd0, 4'd14);
        chk("cur_other_sym", {red, green, blue}, 'h00A);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
